// File: rtl/counter_arbiter.sv
// Round-robin arbiter granting two requesters access to one shared BCD counter.
// Sequence per grant: ISSUE (request pulse), GUARD, WAIT (for CntReady or timeout), DONE (Ack).
module counter_arbiter #(
  parameter int WIDTH   = 12,
  parameter int TIMEOUT = 1023
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             ReqA,
  input  logic             ReqB,
  input  logic             DecA,
  input  logic             DecB,
  input  logic             SetA,
  input  logic             SetB,
  input  logic             SetZeroA,
  input  logic             SetZeroB,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  output logic             AckA,
  output logic             AckB,
  output logic [1:0]       Grant,
  output logic             Busy,
  output logic             TimeoutErr,
  output logic             CntRequest,
  output logic             CntDec,
  output logic             CntSet,
  output logic             CntSetZero,
  output logic [WIDTH-1:0] CntIn,
  input  logic             CntReady
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_GUARD = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   wait_cnt_r;
  logic [CW-1:0]   wait_inc_s;
  logic            last_b_r;
  logic            pick_b_s;
  logic            grant_s;
  logic            timeout_s;

  // Next-state, arbitration and timeout decision
  always_comb begin
    state_s    = state_r;
    pick_b_s   = 1'b0;
    grant_s    = 1'b0;
    timeout_s  = 1'b0;
    wait_inc_s = wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    case (state_r)
      S_IDLE: begin
        if (CntReady && (ReqA || ReqB)) begin
          state_s = S_ISSUE;
          grant_s = 1'b1;
          // Tie goes to whoever was not served last
          if (ReqA && ReqB) begin
            pick_b_s = ~last_b_r;
          end else begin
            pick_b_s = ReqB;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: state_s = S_GUARD;
      S_GUARD: state_s = S_WAIT;
      S_WAIT: begin
        if (CntReady) begin
          state_s = S_DONE;
        end else if (wait_inc_s == TIMEOUT_C) begin
          state_s   = S_DONE;
          timeout_s = 1'b1;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, handshake outputs, wait counter, sticky error and round-robin history
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r    <= S_IDLE;
      Busy       <= 1'b0;
      CntRequest <= 1'b0;
      AckA       <= 1'b0;
      AckB       <= 1'b0;
      wait_cnt_r <= {CW{1'b0}};
      TimeoutErr <= 1'b0;
      last_b_r   <= 1'b1;
    end else begin
      state_r    <= state_s;
      Busy       <= (state_s != S_IDLE);
      CntRequest <= (state_s == S_ISSUE);
      AckA       <= (state_s == S_DONE) && Grant[0];
      AckB       <= (state_s == S_DONE) && Grant[1];
      wait_cnt_r <= (state_r == S_WAIT) ? wait_inc_s : {CW{1'b0}};
      if (timeout_s) begin
        TimeoutErr <= 1'b1;
      end
      if (state_r == S_DONE) begin
        last_b_r <= Grant[1];
      end
    end
  end

  // Owner and command latch: loaded at grant, held to DONE, cleared back in IDLE
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Grant      <= 2'b00;
      CntDec     <= 1'b0;
      CntSet     <= 1'b0;
      CntSetZero <= 1'b0;
      CntIn      <= {WIDTH{1'b0}};
    end else if (grant_s) begin
      Grant      <= pick_b_s ? 2'b10 : 2'b01;
      CntDec     <= pick_b_s ? DecB : DecA;
      CntSet     <= pick_b_s ? SetB : SetA;
      CntSetZero <= pick_b_s ? SetZeroB : SetZeroA;
      CntIn      <= pick_b_s ? InB : InA;
    end else if (state_s == S_IDLE) begin
      Grant      <= 2'b00;
      CntDec     <= 1'b0;
      CntSet     <= 1'b0;
      CntSetZero <= 1'b0;
      CntIn      <= {WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Randomized scoreboard bench for counter_arbiter: the driver predicts each grant
// from round-robin rules and queues the expected transaction; a monitor checks it.
module tb_counter_arbiter;

  localparam int W  = 12;
  localparam int TO = 8;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         ReqA = 1'b0, ReqB = 1'b0;
  logic         DecA = 1'b0, DecB = 1'b0, SetA = 1'b0, SetB = 1'b0;
  logic         SetZeroA = 1'b0, SetZeroB = 1'b0;
  logic [W-1:0] InA = '0, InB = '0;
  logic         CntReady = 1'b0;
  logic         AckA, AckB, Busy, TimeoutErr, CntRequest, CntDec, CntSet, CntSetZero;
  logic [1:0]   Grant;
  logic [W-1:0] CntIn;

  counter_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ReqA(ReqA), .ReqB(ReqB),
    .DecA(DecA), .DecB(DecB), .SetA(SetA), .SetB(SetB),
    .SetZeroA(SetZeroA), .SetZeroB(SetZeroB), .InA(InA), .InB(InB),
    .AckA(AckA), .AckB(AckB), .Grant(Grant), .Busy(Busy), .TimeoutErr(TimeoutErr),
    .CntRequest(CntRequest), .CntDec(CntDec), .CntSet(CntSet), .CntSetZero(CntSetZero),
    .CntIn(CntIn), .CntReady(CntReady)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit           own_b;
    bit           dec;
    bit           set;
    bit           sz;
    logic [W-1:0] din;
    int           lat;
    bit           err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  bit   act = 1'b0;
  int   cyc = 0;
  bit   last_b = 1'b1;
  bit   err_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the head of the scoreboard every cycle
  always @(negedge Clk) begin
    if (mon_en) begin
      if (Busy) begin
        if (!act) begin
          act = 1'b1;
          cyc = 0;
        end else begin
          cyc++;
        end
        chk("queue_depth", sb.size(), 1);
        if (sb.size() != 0) begin
          e = sb[0];
          chk("grant", {30'd0, Grant}, e.own_b ? 32'd2 : 32'd1);
          chk("cnt_cmd", {17'd0, CntDec, CntSet, CntSetZero, CntIn}, {17'd0, e.dec, e.set, e.sz, e.din});
          chk("cnt_request", {31'd0, CntRequest}, (cyc == 0) ? 32'd1 : 32'd0);
          chk("ack", {30'd0, AckB, AckA}, (cyc == e.lat) ? (e.own_b ? 32'd2 : 32'd1) : 32'd0);
          if (cyc >= e.lat || AckA || AckB) begin
            chk("timeout_err", {31'd0, TimeoutErr}, {31'd0, e.err});
            void'(sb.pop_front());
            act = 1'b0;
          end
        end
      end else begin
        act = 1'b0;
        chk("idle_outputs", {14'd0, Grant, CntRequest, CntDec, CntSet, CntSetZero, CntIn, AckA, AckB}, 32'd0);
      end
    end
  end

  task automatic raise(input bit b);
    if (!b) begin
      DecA = 1'($urandom_range(1, 0)); SetA = ($urandom_range(3, 0) == 0);
      SetZeroA = ($urandom_range(3, 0) == 0); InA = W'($urandom); ReqA = 1'b1;
    end else begin
      DecB = 1'($urandom_range(1, 0)); SetB = ($urandom_range(3, 0) == 0);
      SetZeroB = ($urandom_range(3, 0) == 0); InB = W'($urandom); ReqB = 1'b1;
    end
  endtask

  task automatic run_txn(input bit tie);
    int   r, k, d, w;
    bit   g, other_b, own_b, drop, keep;
    exp_t x;
    r = tie ? 2 : int'($urandom_range(2, 0));
    if ((r == 0 || r == 2) && !ReqA) raise(1'b0);
    if ((r == 1 || r == 2) && !ReqB) raise(1'b1);
    // Optionally hold CntReady low; a short pulse on the idle side must be lost
    if ($urandom_range(3, 0) == 0) begin
      CntReady = 1'b0;
      k = int'($urandom_range(4, 1));
      other_b = ReqA;
      g = other_b ? !ReqB : !ReqA;
      if (g) raise(other_b);
      for (int j = 0; j < k; j++) begin
        @(negedge Clk);
        chk("blocked_idle", {29'd0, Busy, Grant}, 32'd0);
        if (g && j == 0) begin
          if (other_b) ReqB = 1'b0; else ReqA = 1'b0;
        end
      end
    end
    CntReady = 1'b1;
    own_b = (ReqA && ReqB) ? !last_b : ReqB;
    last_b = own_b;
    d = int'($urandom_range(10, 0));
    w = (d < TO) ? d + 1 : TO;
    if (d >= TO) err_m = 1'b1;
    x.own_b = own_b;
    x.dec = own_b ? DecB : DecA;
    x.set = own_b ? SetB : SetA;
    x.sz  = own_b ? SetZeroB : SetZeroA;
    x.din = own_b ? InB : InA;
    x.lat = 2 + w;
    x.err = err_m;
    sb.push_back(x);
    drop = ($urandom_range(3, 0) == 0);
    keep = ($urandom_range(4, 0) == 0);
    for (int c = 0; c <= 2 + w; c++) begin
      @(negedge Clk);
      CntReady = (c < 2) ? 1'($urandom_range(1, 0)) : (c - 2 >= d);
      if (c == 1 && drop) begin
        // Late drop must not abort; scrambled qualifiers must not leak through
        if (own_b) begin ReqB = 1'b0; InB = W'($urandom); SetB = ~SetB; end
        else begin ReqA = 1'b0; InA = W'($urandom); DecA = ~DecA; end
      end
      if (c == 2 + w && !keep) begin
        if (own_b) ReqB = 1'b0; else ReqA = 1'b0;
      end
    end
    @(negedge Clk);
  endtask

  task automatic reset_in_wait();
    exp_t x;
    ReqA = 1'b0; ReqB = 1'b0;
    @(negedge Clk);
    raise(1'b0);
    CntReady = 1'b1;
    x.own_b = 1'b0; x.dec = DecA; x.set = SetA; x.sz = SetZeroA; x.din = InA;
    x.lat = 99; x.err = err_m;
    sb.push_back(x);
    @(negedge Clk);
    CntReady = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    #2 Rst_n = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("reset_outputs", {13'd0, AckA, AckB, Grant, Busy, TimeoutErr, CntRequest, CntDec, CntSet, CntSetZero, CntIn}, 32'd0);
    sb.delete();
    ReqA = 1'b0;
    last_b = 1'b1;
    err_m = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    chk("reset_state", {13'd0, AckA, AckB, Grant, Busy, TimeoutErr, CntRequest, CntDec, CntSet, CntSetZero, CntIn}, 32'd0);
    Rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge Clk);
    for (int i = 0; i < 40; i++) begin
      if (i == 20) reset_in_wait();
      run_txn(i == 0 || i == 20);
    end
    ReqA = 1'b0; ReqB = 1'b0;
    repeat (20) @(negedge Clk);
    chk("queue_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
